cs02_stream_core: RTL and testbench

- Core logic of the CS02 FPGA.
- Receives a parity-protected I/Q sample stream on the north high-speed header.
- Applies a 1024-entry subcarrier enable mask to the stream and forwards a 12-bit reduced stream on the west header.
- Exposes control/status registers to the board controller through a MIB slave at address nibble 0x2.

---
 rtl/cs02_stream_core.sv | 247 ++++++++++++++++++++++++
 tb/tb_cs02_stream_core.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cs02_stream_core.sv
// cs02_stream_core -- core logic of the CS02 FPGA.
//
// Takes a parity-protected 18-bit I/Q sample stream from the north header.
// A 1024-entry subcarrier enable mask gates each sample onto the west header.
// The west header carries the top 11 bits of the selected channel.
// Control and status registers are reached through a MIB slave.
//
// Ports:
//   i_sysclk      system clock; all logic is synchronous to it
//   i_srst        asynchronous, active-high reset
//   HS_NORTH_IN   [47] valid, [46:29] Q, [28:11] I, [10] parity
//   HS_WEST_OUT   [47] output valid, [46:36] output sample
//   led_check     heartbeat; toggles every 2^6 (SIM_MODE) or 2^22 valid samples
//   MIB_START     master address-phase-1 strobe
//   MIB_RD_WR_N   1 = read, 0 = write; sampled with MIB_START
//   MIB_ACK       slave acknowledge
//   MIB_AD        shared address/data bus; driven only while returning read data
module cs02_stream_core #(
    parameter logic [3:0] P_MIB_MSN              = 4'h2,
    parameter int         P_CMD_ACK_TIMEOUT_CLKS = 16,
    parameter int         SIM_MODE               = 0
) (
    input  logic         i_sysclk,
    input  logic         i_srst,
    input  logic [47:10] HS_NORTH_IN,
    output logic [47:36] HS_WEST_OUT,
    output logic         led_check,
    input  logic         MIB_START,
    input  logic         MIB_RD_WR_N,
    output logic         MIB_ACK,
    inout  wire  [15:0]  MIB_AD
);

    localparam logic [31:0]   ID_VALUE = 32'hC502_0001;
    localparam int            TW       = $clog2(P_CMD_ACK_TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(P_CMD_ACK_TIMEOUT_CLKS - 1);
    localparam int            HB_W     = (SIM_MODE != 0) ? 6 : 22;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR_LO, S_WR_HI, S_WR_LO, S_RD_TA, S_RD_HI, S_DONE, S_WAIT
    } mib_state_e;

    typedef enum logic [2:0] {
        R_NONE, R_ID, R_CTRL, R_SCNT, R_PERR, R_MASK, R_MCTRL
    } reg_sel_e;

    // Word-offset decode within the slave's 1 MB window.
    function automatic reg_sel_e decode(input logic [19:2] off);
        reg_sel_e sel;
        sel = R_NONE;
        if (off[19:4] == 16'h0000) begin
            case (off[3:2])
                2'd0:    sel = R_ID;
                2'd1:    sel = R_CTRL;
                2'd2:    sel = R_SCNT;
                default: sel = R_PERR;
            endcase
        end else if (off[19:7] == 13'h0200) begin
            sel = R_MASK;
        end else if (off == 18'h04020) begin
            sel = R_MCTRL;
        end
        return sel;
    endfunction

    // ---------------- registers ----------------
    mib_state_e        state_q, state_d;
    logic              ack_q, ack_d;
    logic              oe_q, oe_d;
    logic [15:0]       ad_out_q, ad_out_d;
    logic              rd_q;
    logic [7:0]        addr_hi_q;
    logic [19:2]       off_q;
    logic [15:0]       wdata_hi_q;
    logic [15:0]       rdata_lo_q;
    logic [TW-1:0]     tmo_q;

    logic [31:0]       ctrl_q;
    logic [31:0][31:0] mask_q;
    logic              bypass_q;
    logic [31:0]       scnt_q, perr_cnt_q;
    logic [9:0]        idx_q;
    logic [HB_W-1:0]   hb_q;
    logic              led_q;

    logic [47:10]      in_q;
    logic [1:0]        vld_pipe_q;
    logic [10:0]       s1_data_q, out_data_q;

    // ---------------- MIB slave ----------------
    logic [31:0] wdata, rdata;
    reg_sel_e    cur_sel, bus_sel;
    logic        wr_en, clr_cnt;

    assign wdata   = {wdata_hi_q, MIB_AD};
    assign cur_sel = decode(off_q);
    // Live decode during the second address phase, before off_q is loaded.
    assign bus_sel = decode({addr_hi_q[3:0], MIB_AD[15:2]});
    assign wr_en   = (state_q == S_WR_LO);
    assign clr_cnt = wr_en && (cur_sel == R_CTRL) && wdata[2];

    assign MIB_AD  = oe_q ? ad_out_q : 16'hzzzz;
    assign MIB_ACK = ack_q;

    always_comb begin
        rdata = '0;
        case (cur_sel)
            R_ID:    rdata = ID_VALUE;
            R_CTRL:  rdata = ctrl_q;
            R_SCNT:  rdata = scnt_q;
            R_PERR:  rdata = perr_cnt_q;
            R_MASK:  rdata = mask_q[off_q[6:2]];
            R_MCTRL: rdata = {31'd0, bypass_q};
            default: rdata = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ack_d    = 1'b0;
        oe_d     = 1'b0;
        ad_out_d = ad_out_q;
        case (state_q)
            S_IDLE:    if (MIB_START) state_d = S_ADDR_LO;
            S_ADDR_LO: begin
                // Foreign nibble: drop silently. Own nibble but no register: sit out the timeout.
                if (addr_hi_q[7:4] != P_MIB_MSN) state_d = S_IDLE;
                else if (bus_sel == R_NONE)      state_d = S_WAIT;
                else if (rd_q)                   state_d = S_RD_TA;
                else                             state_d = S_WR_HI;
            end
            S_WR_HI:   state_d = S_WR_LO;
            S_WR_LO: begin
                ack_d   = 1'b1;
                state_d = S_DONE;
            end
            S_RD_TA: begin
                oe_d     = 1'b1;
                ack_d    = 1'b1;
                ad_out_d = rdata[31:16];
                state_d  = S_RD_HI;
            end
            S_RD_HI: begin
                oe_d     = 1'b1;
                ack_d    = 1'b1;
                ad_out_d = rdata_lo_q;
                state_d  = S_DONE;
            end
            S_DONE:    state_d = S_IDLE;
            S_WAIT:    if (tmo_q >= TMO_LAST) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_sysclk or posedge i_srst) begin
        if (i_srst) begin
            state_q    <= S_IDLE;
            ack_q      <= 1'b0;
            oe_q       <= 1'b0;
            ad_out_q   <= '0;
            rd_q       <= 1'b0;
            addr_hi_q  <= '0;
            off_q      <= '0;
            wdata_hi_q <= '0;
            rdata_lo_q <= '0;
            tmo_q      <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            oe_q     <= oe_d;
            ad_out_q <= ad_out_d;
            // tmo_q counts clocks since the START cycle; only the unmapped wait looks at it.
            if (state_q == S_IDLE && MIB_START) begin
                rd_q      <= MIB_RD_WR_N;
                addr_hi_q <= MIB_AD[7:0];
                tmo_q     <= TW'(1);
            end else if (state_q != S_IDLE) begin
                tmo_q <= tmo_q + TW'(1);
            end
            if (state_q == S_ADDR_LO) off_q      <= {addr_hi_q[3:0], MIB_AD[15:2]};
            if (state_q == S_WR_HI)   wdata_hi_q <= MIB_AD;
            if (state_q == S_RD_TA)   rdata_lo_q <= rdata[15:0];
        end
    end

    // ---------------- control / mask registers ----------------
    always_ff @(posedge i_sysclk or posedge i_srst) begin
        if (i_srst) begin
            ctrl_q   <= '0;
            mask_q   <= '1;
            bypass_q <= 1'b0;
        end else if (wr_en) begin
            case (cur_sel)
                R_CTRL:  ctrl_q <= {wdata[31:3], 1'b0, wdata[1:0]};  // bit2 is a strobe only
                R_MASK:  mask_q[off_q[6:2]] <= wdata;
                R_MCTRL: bypass_q <= wdata[0];
                default: ;
            endcase
        end
    end

    // ---------------- sample stream ----------------
    logic in_vld, in_perr, mask_en;

    assign in_vld  = in_q[47];
    assign in_perr = (^in_q[46:11]) ^ in_q[10];
    // Mask is read from the current register state, so a write landing this
    // same edge is only seen by the next sample.
    assign mask_en = bypass_q | mask_q[idx_q[9:5]][idx_q[4:0]];

    always_ff @(posedge i_sysclk or posedge i_srst) begin
        if (i_srst) begin
            in_q       <= '0;
            vld_pipe_q <= '0;
            s1_data_q  <= '0;
            out_data_q <= '0;
            idx_q      <= '0;
            scnt_q     <= '0;
            perr_cnt_q <= '0;
            hb_q       <= '0;
            led_q      <= 1'b0;
        end else begin
            in_q          <= HS_NORTH_IN;
            vld_pipe_q[0] <= in_vld & ctrl_q[0] & mask_en;
            vld_pipe_q[1] <= vld_pipe_q[0];
            if (in_vld)        s1_data_q  <= ctrl_q[1] ? in_q[46:36] : in_q[28:18];
            if (vld_pipe_q[0]) out_data_q <= s1_data_q;

            if (in_vld) begin
                idx_q <= idx_q + 10'd1;
                hb_q  <= hb_q + HB_W'(1);
                if (hb_q == '1) led_q <= ~led_q;
            end

            // Clear wins over a coincident increment.
            if (clr_cnt)                      scnt_q <= '0;
            else if (in_vld && scnt_q != '1)  scnt_q <= scnt_q + 32'd1;

            if (clr_cnt)                                 perr_cnt_q <= '0;
            else if (in_vld && in_perr && perr_cnt_q != '1) perr_cnt_q <= perr_cnt_q + 32'd1;
        end
    end

    assign HS_WEST_OUT = {vld_pipe_q[1], out_data_q};
    assign led_check   = led_q;

endmodule

// File: tb/tb_cs02_stream_core.sv
// Scoreboard bench for cs02_stream_core: stimulus pushes expected MIB acks and
// west-header samples into queues; a negedge monitor pops and compares them.
module tb_cs02_stream_core;

    localparam int P_TMO = 16;

    logic         clk = 1'b0;
    logic         srst;
    logic [47:10] north;
    wire  [47:36] west;
    wire          led;
    logic         start, rdwr;
    wire          ack;
    wire  [15:0]  mib_ad;
    logic         tb_drv;
    logic [15:0]  tb_ad;

    always #5 clk = ~clk;
    assign mib_ad = tb_drv ? tb_ad : 16'hzzzz;

    cs02_stream_core #(.P_MIB_MSN(4'h2), .P_CMD_ACK_TIMEOUT_CLKS(P_TMO), .SIM_MODE(1)) dut (
        .i_sysclk(clk), .i_srst(srst), .HS_NORTH_IN(north), .HS_WEST_OUT(west),
        .led_check(led), .MIB_START(start), .MIB_RD_WR_N(rdwr), .MIB_ACK(ack), .MIB_AD(mib_ad));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0, n_fail = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm, input int act, input int exp);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_ctrl;
    bit          m_mask[1024];
    bit          m_bypass;
    longint      m_scnt, m_perr;
    int          m_idx, m_total;

    function automatic void model_reset();
        m_ctrl = 0; m_bypass = 0; m_scnt = 0; m_perr = 0; m_idx = 0; m_total = 0;
        foreach (m_mask[i]) m_mask[i] = 1'b1;
    endfunction

    function automatic logic [31:0] sat32(input longint v);
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(v);
    endfunction

    function automatic logic [31:0] model_read(input logic [23:0] a);
        int off;
        logic [31:0] w;
        off = int'(a[19:0]) & ~3;
        w = 0;
        if (off == 0)       w = 32'hC502_0001;
        else if (off == 4)  w = m_ctrl;
        else if (off == 8)  w = sat32(m_scnt);
        else if (off == 12) w = sat32(m_perr);
        else if (off >= 'h10000 && off < 'h10080)
            for (int b = 0; b < 32; b++) w[b] = m_mask[(off - 'h10000) / 4 * 32 + b];
        else if (off == 'h10080) w = {31'd0, m_bypass};
        return w;
    endfunction

    function automatic void model_write(input logic [23:0] a, input logic [31:0] d);
        int off;
        off = int'(a[19:0]) & ~3;
        if (off == 4) begin
            m_ctrl = d & ~32'h4;
            if (d[2]) begin m_scnt = 0; m_perr = 0; end
        end else if (off >= 'h10000 && off < 'h10080) begin
            for (int b = 0; b < 32; b++) m_mask[(off - 'h10000) / 4 * 32 + b] = d[b];
        end else if (off == 'h10080) begin
            m_bypass = d[0];
        end
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct { int cyc; bit rd; logic [15:0] d; string nm; } mib_exp_t;
    typedef struct { int cyc; logic [10:0] d; } out_exp_t;
    mib_exp_t mib_q[$];
    out_exp_t out_q[$];

    always @(negedge clk) begin
        if (!srst) begin
            while (mib_q.size() > 0 && mib_q[0].cyc < cyc) begin
                flag({mib_q[0].nm, "_ack_missing"}, 0, 1);
                void'(mib_q.pop_front());
            end
            if (ack) begin
                if (mib_q.size() == 0) flag("mib_ack_unexpected", cyc, -1);
                else begin
                    mib_exp_t e;
                    e = mib_q.pop_front();
                    check({e.nm, "_ack_cyc"}, 64'(cyc), 64'(e.cyc));
                    if (e.rd) check({e.nm, "_data"}, 64'(mib_ad), 64'(e.d));
                end
            end else if (!tb_drv) begin
                check("mib_ad_hiz", 64'(mib_ad === 16'hzzzz || mib_ad === 16'h0000), 64'd1);
            end

            while (out_q.size() > 0 && out_q[0].cyc < cyc) begin
                flag("west_valid_missing", 0, 1);
                void'(out_q.pop_front());
            end
            if (west[47]) begin
                if (out_q.size() == 0) flag("west_valid_unexpected", cyc, -1);
                else begin
                    out_exp_t o;
                    o = out_q.pop_front();
                    check("west_cyc", 64'(cyc), 64'(o.cyc));
                    check("west_data", 64'(west[46:36]), 64'(o.d));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic mib_read(input logic [23:0] a, input bit mapped, input string nm);
        logic [31:0] e;
        e = model_read(a);
        tick();
        start = 1; rdwr = 1; tb_drv = 1; tb_ad = {8'h00, a[23:16]};
        if (mapped) begin
            mib_q.push_back(mib_exp_t'{cyc + 3, 1'b1, e[31:16], nm});
            mib_q.push_back(mib_exp_t'{cyc + 4, 1'b1, e[15:0], nm});
        end
        tick(); start = 0; tb_ad = a[15:0];
        tick(); tb_drv = 0;
        if (mapped) repeat (4) tick();
        else repeat (P_TMO + 3) tick();
    endtask

    task automatic mib_write(input logic [23:0] a, input logic [31:0] d, input bit mapped, input string nm);
        tick();
        start = 1; rdwr = 0; tb_drv = 1; tb_ad = {8'h00, a[23:16]};
        if (mapped) mib_q.push_back(mib_exp_t'{cyc + 4, 1'b0, 16'h0, nm});
        tick(); start = 0; tb_ad = a[15:0];
        tick(); tb_ad = d[31:16];
        tick(); tb_ad = d[15:0];
        tick(); tb_drv = 0;
        if (mapped) begin
            model_write(a, d);
            repeat (2) tick();
        end else repeat (P_TMO) tick();
    endtask

    task automatic send(input logic [17:0] i_s, input logic [17:0] q_s, input bit bad, input bit v);
        tick();
        north = {v, q_s, i_s, (^{q_s, i_s}) ^ bad};
        if (v) begin
            m_scnt++; m_total++;
            if (bad) m_perr++;
            if (m_ctrl[0] && (m_bypass || m_mask[m_idx]))
                out_q.push_back(out_exp_t'{cyc + 3, m_ctrl[1] ? q_s[17:7] : i_s[17:7]});
            m_idx = (m_idx + 1) % 1024;
        end
    endtask

    task automatic stream_end();
        tick(); north = '0;
        repeat (5) tick();
        check("led_check", 64'(led), 64'((m_total / 64) % 2));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "bench timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        int t;
        logic [31:0] d;
        srst = 1; north = '0; start = 0; rdwr = 0; tb_drv = 0; tb_ad = '0;
        model_reset();
        repeat (3) tick();
        srst = 0;
        tick();
        check("rst_west", 64'(west), 64'd0);
        check("rst_led", 64'(led), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);

        mib_read(24'h200000, 1, "rd_id");
        mib_read(24'h200008, 1, "rd_scnt_rst");
        mib_read(24'h21007C, 1, "rd_mask31_rst");

        mib_write(24'h200004, 32'h0101_0202, 1, "wr_ctrl");
        mib_read(24'h200004, 1, "rd_ctrl");
        for (int n = 0; n < 8; n++) send(18'(n), 18'(-n), 1'b0, 1'b1);
        stream_end();

        // Enable output, clear counters, mask out subcarriers 0..31.
        mib_write(24'h200004, 32'h0000_0005, 1, "wr_ctrl_en");
        mib_write(24'h210000, 32'h0, 1, "wr_mask0");
        for (int n = 0; n < 100; n++) send(18'(n), 18'(-n), 1'b0, 1'b1);
        stream_end();
        mib_read(24'h200008, 1, "rd_scnt100");

        send(18'h1234, 18'h2345, 1'b1, 1'b1);
        stream_end();
        mib_read(24'h20000C, 1, "rd_perr1");
        mib_write(24'h200004, 32'h0000_0005, 1, "wr_ctrl_clr");
        mib_read(24'h200008, 1, "rd_scnt_clr");
        mib_read(24'h20000C, 1, "rd_perr_clr");

        // Random masks, swap, scratch bits, sparse valids and parity errors.
        for (int k = 0; k < 32; k++) begin
            d = $urandom;
            mib_write(24'h210000 + 24'(k * 4), d, 1, "wr_mask_rand");
        end
        d = ($urandom & ~32'h7) | 32'h3;
        mib_write(24'h200004, d, 1, "wr_ctrl_rand");
        mib_read(24'h200004, 1, "rd_ctrl_rand");
        mib_read(24'h210054, 1, "rd_mask21");
        for (int n = 0; n < 700; n++)
            send(18'($urandom), 18'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 4) != 0);
        stream_end();
        mib_read(24'h200008, 1, "rd_scnt_rand");
        mib_read(24'h20000C, 1, "rd_perr_rand");

        mib_write(24'h210080, 32'h1, 1, "wr_bypass");
        mib_write(24'h200004, 32'h0000_0001, 1, "wr_ctrl_noswap");
        mib_read(24'h210080, 1, "rd_bypass");
        for (int n = 0; n < 600; n++)
            send(18'($urandom), 18'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
        stream_end();
        mib_read(24'h200008, 1, "rd_scnt_byp");

        // Unmapped address in our nibble, with a START inside the wait that must be ignored.
        tick(); t = cyc;
        start = 1; rdwr = 1; tb_drv = 1; tb_ad = 16'h002F;
        tick(); start = 0; tb_ad = 16'hFFF0;
        tick(); tb_drv = 0;
        while (cyc < t + 8) tick();
        start = 1; rdwr = 1; tb_drv = 1; tb_ad = 16'h0020;
        tick(); start = 0; tb_ad = 16'h0000;
        tick(); tb_drv = 0;
        while (cyc < t + P_TMO - 1) tick();
        mib_read(24'h200000, 1, "rd_id_after_tmo");   // START lands exactly t+16
        mib_read(24'h300000, 0, "rd_foreign");
        mib_write(24'h300004, 32'h0, 0, "wr_foreign");
        mib_write(24'h2FFFF0, 32'h0, 0, "wr_unmapped");
        mib_read(24'h200004, 1, "rd_ctrl_untouched");

        // Reset in the middle of a write.
        tick(); start = 1; rdwr = 0; tb_drv = 1; tb_ad = 16'h0020;
        tick(); start = 0; tb_ad = 16'h0004;
        tick(); tb_ad = 16'h0000; srst = 1;
        tick(); tb_drv = 0;
        tick(); srst = 0;
        model_reset();
        check("rst2_west", 64'(west), 64'd0);
        check("rst2_led", 64'(led), 64'd0);
        check("rst2_ack", 64'(ack), 64'd0);
        repeat (3) tick();
        mib_read(24'h200004, 1, "rd_ctrl_rst2");
        mib_read(24'h210000, 1, "rd_mask0_rst2");
        mib_read(24'h210080, 1, "rd_bypass_rst2");
        mib_read(24'h200008, 1, "rd_scnt_rst2");
        mib_write(24'h210004, 32'h0, 1, "wr_mask1");
        mib_write(24'h200004, 32'h0000_0003, 1, "wr_ctrl_rst2");
        for (int n = 0; n < 80; n++) send(18'($urandom), 18'($urandom), 1'b0, 1'b1);
        stream_end();
        mib_read(24'h200008, 1, "rd_scnt_end");

        repeat (5) tick();
        check("mib_q_drained", 64'(mib_q.size()), 64'd0);
        check("out_q_drained", 64'(out_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
